// File: rtl/seg_fetch_pkg.sv
// Shared types and sizes for the segment-mapped line fetch unit.
// 21-bit physical space (2MB), one 16-byte line = 8 words, tag is phys[20:4].
package seg_fetch_pkg;
    localparam int LINE_WORDS = 8;
    localparam int DATA_W     = 16;
    localparam int PHYS_W     = 21;
    localparam int TAG_W      = 17;

    typedef enum logic [2:0] {
        IDLE,
        XLAT,
        LOOKUP,
        FILL_CMD,
        FILL_DATA,
        WR_CMD,
        RESP
    } fetch_state_e;
endpackage

// File: rtl/seg_line_buf.sv
// Line buffer: small register file with one byte-enabled write port and
// one asynchronous read port.
module seg_line_buf import seg_fetch_pkg::*; #(
    parameter int WORDS = LINE_WORDS,
    parameter int DW    = DATA_W,
    localparam int AW   = $clog2(WORDS)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    be,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [WORDS];

    always_ff @(posedge CLK) begin
        if (we) begin
            if (be[0]) mem[waddr][DW/2-1:0]  <= wdata[DW/2-1:0];
            if (be[1]) mem[waddr][DW-1:DW/2] <= wdata[DW-1:DW/2];
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/seg_line_fetch.sv
// CPU-side front end to the SDRAM controller: segment translation through the
// external mapper, a single-line read buffer with burst fill, write-through stores.
module seg_line_fetch #(
    parameter int LINE_WORDS = 8,
    parameter int DATA_W     = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [19:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_be,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [5:0]        seg_memaddr,
    input  logic [6:0]        seg_memdata,
    input  logic              map_change,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [20:0]       mem_cmd_addr,
    output logic [DATA_W-1:0] mem_cmd_wdata,
    output logic [1:0]        mem_cmd_be,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data
);
    import seg_fetch_pkg::*;

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int LOFF  = IDX_W + 1;

    fetch_state_e      state;
    logic [19:0]       cap_addr;
    logic              cap_we;
    logic [DATA_W-1:0] cap_wdata;
    logic [1:0]        cap_be;
    logic [PHYS_W-1:0] phys;
    logic [TAG_W-1:0]  line_tag;
    logic              line_valid;
    logic              stale;
    logic              hit_r;
    logic [IDX_W-1:0]  cnt;

    logic              hit;
    logic              last_beat;
    logic              buf_we;
    logic [IDX_W-1:0]  buf_waddr;
    logic [1:0]        buf_be;
    logic [DATA_W-1:0] buf_wdata;
    logic [DATA_W-1:0] buf_rdata;

    assign hit       = line_valid && (line_tag == phys[PHYS_W-1:LOFF]);
    assign last_beat = mem_rd_valid && (cnt == IDX_W'(LINE_WORDS - 1));

    // Fill beats and write-hit merges share the single buffer write port.
    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = cnt;
        buf_be    = 2'b11;
        buf_wdata = mem_rd_data;
        if (state == FILL_DATA && mem_rd_valid) begin
            buf_we = 1'b1;
        end else if (state == WR_CMD && mem_cmd_ready && hit_r) begin
            buf_we    = 1'b1;
            buf_waddr = phys[LOFF-1:1];
            buf_be    = cap_be;
            buf_wdata = cap_wdata;
        end
    end

    seg_line_buf #(.WORDS(LINE_WORDS), .DW(DATA_W)) u_buf (
        .CLK   (CLK),
        .we    (buf_we),
        .waddr (buf_waddr),
        .be    (buf_be),
        .wdata (buf_wdata),
        .raddr (phys[LOFF-1:1]),
        .rdata (buf_rdata)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            cap_addr      <= '0;
            cap_we        <= 1'b0;
            cap_wdata     <= '0;
            cap_be        <= '0;
            phys          <= '0;
            line_tag      <= '0;
            line_valid    <= 1'b0;
            stale         <= 1'b0;
            hit_r         <= 1'b0;
            cnt           <= '0;
            cpu_ready     <= 1'b0;
            cpu_rdata     <= '0;
            seg_memaddr   <= '0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_wdata <= '0;
            mem_cmd_be    <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        cap_addr    <= cpu_addr;
                        cap_we      <= cpu_we;
                        cap_wdata   <= cpu_wdata;
                        cap_be      <= cpu_be;
                        seg_memaddr <= cpu_addr[19:14];
                        state       <= XLAT;
                    end
                end
                XLAT: begin
                    phys  <= {seg_memdata, cap_addr[13:0]};
                    state <= LOOKUP;
                end
                LOOKUP: begin
                    hit_r <= hit;
                    if (cap_we) begin
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_we    <= 1'b1;
                        mem_cmd_addr  <= phys;
                        mem_cmd_wdata <= cap_wdata;
                        mem_cmd_be    <= cap_be;
                        state         <= WR_CMD;
                    end else if (hit) begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= buf_rdata;
                        state     <= RESP;
                    end else begin
                        line_valid    <= 1'b0;
                        stale         <= map_change;
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_we    <= 1'b0;
                        mem_cmd_addr  <= {phys[PHYS_W-1:LOFF], {LOFF{1'b0}}};
                        mem_cmd_wdata <= '0;
                        mem_cmd_be    <= '0;
                        state         <= FILL_CMD;
                    end
                end
                FILL_CMD: begin
                    if (map_change) stale <= 1'b1;
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= FILL_DATA;
                    end
                end
                FILL_DATA: begin
                    if (map_change) stale <= 1'b1;
                    if (mem_rd_valid) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            line_tag   <= phys[PHYS_W-1:LOFF];
                            line_valid <= !(stale || map_change);
                            cpu_ready  <= 1'b1;
                            // The final beat lands in the buffer on this same edge.
                            cpu_rdata  <= (phys[LOFF-1:1] == cnt) ? mem_rd_data : buf_rdata;
                            state      <= RESP;
                        end
                    end
                end
                WR_CMD: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        cpu_ready     <= 1'b1;
                        cpu_rdata     <= '0;
                        state         <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (map_change) line_valid <= 1'b0;
        end
    end
endmodule

// File: doc/seg_line_fetch.md
Name: seg_line_fetch

Overview:
- Sits directly downstream of the segment/EMS mapper, between CPU memory requests and the SDRAM controller command port.
- Drives the mapper's 6-bit CPU segment index (cpu_addr[19:14]) and consumes its 7-bit physical segment (phys[20:14]) to form a 21-bit physical byte address (2MB).
- Holds one 16-byte line buffer: read misses trigger an 8-beat burst fill; writes are write-through.
- A mapper write invalidates the buffer.

Parameters:
- LINE_WORDS, 8, 16-bit words per line; fixed burst length.
- DATA_W, 16, CPU/memory data width in bits.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request; CPU holds it high until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  20  CPU linear byte address (A20 disabled).
- cpu_wdata  in  16  write data.
- cpu_be  in  2  byte enables; [1] = high byte.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  16  read data, valid while cpu_ready = 1.
- seg_memaddr  out  6  to mapper memaddr; registered copy of captured cpu_addr[19:14].
- seg_memdata  in  7  from mapper memdata; physical address bits [20:14].
- map_change  in  1  pulse, driven as mapper WE | WE_EMS.
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  controller accepts the command on valid & ready.
- mem_cmd_we  out  1  1 = single-word write, 0 = line burst read.
- mem_cmd_addr  out  21  physical byte address; line-aligned (bits [3:0] = 0) for reads.
- mem_cmd_wdata  out  16  write data.
- mem_cmd_be  out  2  write byte enables.
- mem_rd_valid  in  1  burst beat valid.
- mem_rd_data  in  16  burst beat data, in ascending word order.

Behaviour:
- Reset, asynchronous on RST_N low:
  - state = IDLE; line_valid = 0.
  - cpu_ready, cpu_rdata, seg_memaddr, mem_cmd_* all 0; beat counter = 0.
  - Reset mid-burst abandons the burst silently.
- States: IDLE, XLAT, LOOKUP, FILL_CMD, FILL_DATA, WR_CMD, RESP.
- IDLE: on cpu_req, capture addr, we, wdata and be; load seg_memaddr; go to XLAT. cpu_req while not in IDLE is ignored (no re-capture).
- XLAT: phys <= {seg_memdata, cap_addr[13:0]}. The mapper is combinational, so one cycle suffices.
- LOOKUP: hit = line_valid & (line_tag == phys[20:4]).
  - Read hit: go to RESP.
  - Read miss: go to FILL_CMD.
  - Write (hit or miss): go to WR_CMD.
- FILL_CMD:
  - Clear line_valid on entry.
  - Drive mem_cmd_valid = 1, mem_cmd_we = 0, mem_cmd_addr = {phys[20:4], 4'h0}; hold stable until mem_cmd_ready.
  - Beat counter = 0; go to FILL_DATA.
- FILL_DATA:
  - Each mem_rd_valid writes buf[cnt] = mem_rd_data and increments cnt.
  - On the 8th beat (cnt == 7): line_tag = phys[20:4]; line_valid = 1 unless a map_change occurred since FILL_CMD entry (sticky stale flag); go to RESP.
  - mem_rd_valid in any other state is ignored.
- WR_CMD:
  - Drive mem_cmd_valid = 1, we = 1, addr = phys, wdata and be; hold until ready.
  - On acceptance, if hit, merge enabled bytes into buf[phys[3:1]].
  - Go to RESP.
- RESP:
  - cpu_ready = 1 for exactly one cycle.
  - Read: cpu_rdata = buf[phys[3:1]] (post-fill). Write: cpu_rdata = 0.
  - Return to IDLE.
- Latency:
  - Read hit: req sampled at cycle 0, cpu_ready at cycle 3.
  - Miss: 3 + command wait + 8 beats + 1.
- Address rules:
  - cpu_addr[0] is ignored; word index = phys[3:1].
  - No carry between the segment and offset fields.
- map_change:
  - Clears line_valid in any state, same cycle edge.
  - If coincident with a LOOKUP hit, the current access still uses the old lookup result; the next access misses.

Decomposition:
- Shared package seg_fetch_pkg: state enum, LINE_WORDS, PHYS_W = 21, TAG_W = 17.
- One sub-module, seg_line_buf: 8x16 register file, one write port with 2-bit byte enables, one asynchronous read port.

Test Plan:
1. Read miss:
   - Stimulus: read 0x04006; bench mapper returns 7'h01 for memaddr 6'h01; issue 8 beats 0x1000..0x1007.
   - Response: mem_cmd_addr = 21'h004000, we = 0; cpu_rdata = 0x1003 with a single cpu_ready pulse.
2. Read hit:
   - Stimulus: read 0x04000 after scenario 1.
   - Response: no mem_cmd_valid; cpu_ready at cycle 3; rdata = 0x1000.
3. EMS window:
   - Stimulus: read 0xA0010; seg_memaddr = 6'h28; mapper returns 7'h45.
   - Response: mem_cmd_addr = 21'h114010 & ~0xF = 21'h114010 (already aligned).
4. Write hit:
   - Stimulus: write 0x04006, be = 2'b10, wdata = 0xAB00; mem_cmd_ready delayed 2 cycles.
   - Response: command held stable, addr = 21'h004006, be = 2'b10; a following read of 0x04006 returns 0xAB03 from the buffer.
5. map_change:
   - Pulse map_change during FILL_DATA beat 4.
     - Response: CPU still gets data; a re-read of the same line issues a new fill.
   - Pulse map_change while idle.
     - Response: the next read misses.
6. Reset:
   - Stimulus: RST_N low for 1 cycle after 3 fill beats.
   - Response: outputs 0 immediately; state IDLE; the subsequent read of the same address refetches.
